// File: rtl/chunk_adder_pkg.sv
// Shared definitions for the chunked adder sequencer.
//   state_e   : sequencer FSM states (IDLE / RUN / DONE)
//   cnt_width : chunk-counter width, max(1, $clog2(chunks))
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/carry_bypass_block.sv
// carry_bypass_block: WIDTH-bit adder slice with carry bypass.
// When every bit position propagates, the carry-in is forwarded straight
// to the carry-out instead of waiting on the ripple chain.
// Ports:
//   iA, iB : WIDTH-bit operand slices
//   iC     : carry-in
//   oS     : WIDTH-bit sum slice
//   oC     : carry-out
module carry_bypass_block #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oS,
  output logic             oC
);

  logic w_prop_all;

  assign w_prop_all = &(iA ^ iB);

  always_comb begin : ripple
    logic w_c;
    oS  = '0;
    w_c = iC;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      oS[i] = iA[i] ^ iB[i] ^ w_c;
      w_c   = (iA[i] & iB[i]) | ((iA[i] ^ iB[i]) & w_c);
    end
    // Full propagate: ripple result equals iC, so take the short path.
    oC = w_prop_all ? iC : w_c;
  end

endmodule

// File: rtl/chunked_adder_sequencer.sv
// chunked_adder_sequencer: multi-cycle wide adder. Accepts two
// WIDTH*CHUNKS-bit operands over valid/ready, feeds one WIDTH-bit slice per
// clock (LSB first) through a carry_bypass_block, and holds the assembled
// result until the downstream stage accepts it.
// Optional feature macro: CHUNK_ADDER_SUB_EN (adds iSub, A-B mode).
// Ports:
//   iClk, iRstN     : clock, async active-low reset
//   iValid / oReady : operand handshake (oReady combinational from state, iReady)
//   iA, iB, iC      : operands and carry-in, sampled on acceptance
//   iSub            : subtract select (only with CHUNK_ADDER_SUB_EN)
//   oValid / iReady : result handshake
//   oS, oC          : sum and final carry-out, valid while oValid=1
module chunked_adder_sequencer
  import chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CHUNKS = 8
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [WIDTH*CHUNKS-1:0]   iA,
  input  logic [WIDTH*CHUNKS-1:0]   iB,
  input  logic                      iC,
`ifdef CHUNK_ADDER_SUB_EN
  input  logic                      iSub,
`endif
  output logic                      oValid,
  input  logic                      iReady,
  output logic [WIDTH*CHUNKS-1:0]   oS,
  output logic                      oC
);

  localparam int unsigned TW = WIDTH * CHUNKS;
  localparam int unsigned CW = cnt_width(CHUNKS);
  localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  logic [TW-1:0]  r_a;
  logic [TW-1:0]  r_b;
  logic [TW-1:0]  r_sum;
  logic           r_carry;
`ifdef CHUNK_ADDER_SUB_EN
  logic           r_sub;
`endif

  logic             w_accept;
  logic [WIDTH-1:0] w_blk_a;
  logic [WIDTH-1:0] w_blk_b;
  logic [WIDTH-1:0] w_blk_s;
  logic             w_blk_c;
  logic [TW-1:0]    w_sum_next;
  logic             w_init_carry;

  assign oReady   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & iReady);
  assign w_accept = iValid & oReady;
  assign oValid   = (r_state == ST_DONE);
  assign oS       = r_sum;
  assign oC       = r_carry;

  assign w_blk_a = r_a[WIDTH-1:0];
`ifdef CHUNK_ADDER_SUB_EN
  // Subtraction as A + ~B + 1: invert each B slice, seed carry with 1.
  assign w_blk_b      = r_b[WIDTH-1:0] ^ {WIDTH{r_sub}};
  assign w_init_carry = iSub | iC;
`else
  assign w_blk_b      = r_b[WIDTH-1:0];
  assign w_init_carry = iC;
`endif

  // New slice enters at the MSB end; after CHUNKS shifts the LSB slice
  // computed first has reached bit 0. Written as shift/OR so it stays
  // legal when CHUNKS=1 (TW == WIDTH).
  assign w_sum_next = (r_sum >> WIDTH) | (TW'(w_blk_s) << (TW - WIDTH));

  carry_bypass_block #(
    .WIDTH(WIDTH)
  ) u_cbb (
    .iA(w_blk_a),
    .iB(w_blk_b),
    .iC(r_carry),
    .oS(w_blk_s),
    .oC(w_blk_c)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
`ifdef CHUNK_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a     <= iA;
            r_b     <= iB;
            r_carry <= w_init_carry;
            r_cnt   <= '0;
`ifdef CHUNK_ADDER_SUB_EN
            r_sub   <= iSub;
`endif
            r_state <= ST_RUN;
          end else if (r_state == ST_DONE && iReady) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> WIDTH;
          r_b     <= r_b >> WIDTH;
          r_sum   <= w_sum_next;
          r_carry <= w_blk_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
